wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage directly downstream of the memory-access stage.
- Holds the MEM/WB pipeline register and owns the 32x32 general register file.
- Merges partial (unaligned-load) data from the memory shifter into the old destination value using per-byte enables.
- Provides bypassed register reads to the decode stage and a forwarding tap to the execute stage, and counts retired instructions.

Parameters:
- NREG, 32, number of architectural registers (r0 hardwired to zero)
- DW, 32, datapath width in bits

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold W register; inhibit write and count this cycle
- flush  in  1  replace incoming instruction with a bubble
- m_valid  in  1  MEM stage holds a real instruction
- m_reg_write_valid  in  1  condition-checked register write enable from MEM
- m_mem_to_reg  in  1  1 = result from load data, 0 = from ALU result
- m_rd  in  5  destination register
- m_alu_result  in  32  ALU/address result from MEM
- m_load_data  in  32  shifted load data from MEM
- m_rd_byte_en  in  4  per-byte destination enable for loads (bit3 = [31:24])
- rs_addr  in  5  decode read port A address
- rt_addr  in  5  decode read port B address
- rs_data  out  32  read port A data (bypassed)
- rt_data  out  32  read port B data (bypassed)
- fwd_valid  out  1  W stage is writing fwd_addr this cycle
- fwd_addr  out  5  W stage destination
- fwd_data  out  32  merged W stage write value
- retired  out  32  retired-instruction counter

Behaviour:
- W register fields are w_valid, w_we, w_mtr, w_rd, w_alu, w_ld and w_ben. They are captured on the rising edge.
- Update priority each edge: rst > flush > stall > load.
  - rst: w_valid=0, all other W fields=0, all registers=0, retired=0.
  - flush (no rst): w_valid=0, w_we=0; other fields don't-care. Flush overrides stall.
  - stall (no rst/flush): W register holds.
  - otherwise: W fields take the m_* inputs. w_valid = m_valid.
- Effective byte enable:
  - ben = w_ben when w_mtr=1.
  - ben = 4'b1111 when w_mtr=0.
  - ben=4'b0000 is legal: a write that changes nothing.
- Merge value:
  - src = w_mtr ? w_ld : w_alu.
  - For each byte i: merged[i] = ben[i] ? src[i] : R[w_rd][i]. The old R[w_rd] is read combinationally in the same cycle.
- wr_en = w_valid & w_we & ~stall & (w_rd != 0). On a rising edge with wr_en=1 (and no rst), R[w_rd] <= merged.
- A write to r0 is dropped. R[0] always reads 0.
- Stalled instruction: no write and no count while stall=1. It writes and counts exactly once, in the first cycle after stall deasserts (unless flush or rst intervenes).
- Forwarding: fwd_valid = wr_en, fwd_addr = w_rd, fwd_data = merged. All are combinational from W state and stall.
- Read ports are combinational:
  - addr 0 returns 0.
  - If wr_en=1 and addr == w_rd, returns merged (write-through bypass).
  - Otherwise returns R[addr].
  - Both ports may read the same address.
- retired increments by 1 on each edge where w_valid & ~stall & ~rst. This counts non-writing, r0-target and overflow-suppressed instructions alike. It wraps FFFFFFFF -> 0.
- Latency: an instruction presented on m_* at edge N writes R at edge N+1. It is visible on read ports via bypass during the cycle between N and N+1, and directly from R after edge N+1.
- Reset outputs: rs_data=0, rt_data=0, fwd_valid=0, fwd_addr=0, fwd_data=0, retired=0.
- Reset mid-stall clears W; the stalled instruction is lost.

Test Plan:
- Reset then ALU write: m_valid=1, we=1, mtr=0, rd=5, alu=0x12345678 -> one cycle later fwd_valid=1, rs_addr=5 returns 0x12345678; after the next edge R5 holds it and retired=1.
- Partial load merge: R7=0xAABBCCDD; load mtr=1, ld=0x11223300, ben=1110, rd=7 -> R7=0x112233DD. Then ben=1000, ld=0x44000000 -> R7=0x442233DD.
- r0 and suppressed write:
  - rd=0, alu=0xFFFFFFFF -> fwd_valid=0, rs(0)=0, retired increments.
  - we=0 (overflow-suppressed), rd=3 -> R3 unchanged, retired increments.
- Stall hold: ALU write rd=9 with stall=1 for 3 cycles -> fwd_valid=0 and retired constant during the stall. On release, exactly one write of R9 and retired +1.
- Flush and stall together: flush=1, stall=1 with m_valid=1, rd=4 -> w_valid=0 next cycle, R4 never written, retired unchanged.
- Counter wrap and mid-stall reset:
  - Force retired to 0xFFFFFFFF via 2^32-1 retires (or hierarchical preload), then one retire -> 0.
  - Assert rst during stall -> all outputs 0, R file cleared.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, 32x32 register file with byte-merge writes,
// bypassed decode read ports, execute forwarding tap and retired-instruction counter.

module wb_byte_merge (
  input  logic       en,
  input  logic [7:0] src,
  input  logic [7:0] old,
  output logic [7:0] merged
);
  assign merged = en ? src : old;
endmodule

module wb_stage #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          m_valid,
  input  logic          m_reg_write_valid,
  input  logic          m_mem_to_reg,
  input  logic [4:0]    m_rd,
  input  logic [DW-1:0] m_alu_result,
  input  logic [DW-1:0] m_load_data,
  input  logic [DW/8-1:0] m_rd_byte_en,
  input  logic [4:0]    rs_addr,
  input  logic [4:0]    rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic          fwd_valid,
  output logic [4:0]    fwd_addr,
  output logic [DW-1:0] fwd_data,
  output logic [31:0]   retired
);
  localparam int NB = DW / 8;

  typedef struct packed {
    logic          valid;
    logic          we;
    logic          mtr;
    logic [4:0]    rd;
    logic [DW-1:0] alu;
    logic [DW-1:0] ld;
    logic [NB-1:0] ben;
  } w_t;

  w_t w, m_in;
  logic [NREG-1:0][DW-1:0] regs;
  logic [NB-1:0]           ben;
  logic [DW-1:0]           src, old, merged;
  logic                    wr_en;
  logic [31:0]             retired_q;

  assign m_in = '{valid: m_valid, we: m_reg_write_valid, mtr: m_mem_to_reg,
                  rd: m_rd, alu: m_alu_result, ld: m_load_data, ben: m_rd_byte_en};

  // Flush only needs to kill valid/we; the payload is don't-care in a bubble.
  always_ff @(posedge clk) begin
    if (rst)
      w <= '0;
    else if (flush) begin
      w.valid <= 1'b0;
      w.we    <= 1'b0;
    end else if (!stall)
      w <= m_in;
  end

  assign ben   = w.mtr ? w.ben : {NB{1'b1}};
  assign src   = w.mtr ? w.ld : w.alu;
  assign old   = regs[w.rd];
  assign wr_en = w.valid & w.we & ~stall & (w.rd != 5'd0);

  for (genvar i = 0; i < NB; i++) begin : g_mrg
    wb_byte_merge u_mrg (
      .en     (ben[i]),
      .src    (src[8*i +: 8]),
      .old    (old[8*i +: 8]),
      .merged (merged[8*i +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)
      regs <= '0;
    else if (wr_en)
      regs[w.rd] <= merged;
  end

  always_ff @(posedge clk) begin
    if (rst)
      retired_q <= '0;
    else if (w.valid && !stall)
      retired_q <= retired_q + 32'd1;
  end

  // Write-through bypass so decode sees the value committed at the coming edge.
  assign rs_data = (rs_addr == 5'd0) ? '0 :
                   (wr_en && rs_addr == w.rd) ? merged : regs[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? '0 :
                   (wr_en && rt_addr == w.rd) ? merged : regs[rt_addr];

  assign fwd_valid = wr_en;
  assign fwd_addr  = w.rd;
  assign fwd_data  = merged;
  assign retired   = retired_q;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: vector table for the datapath, scoreboard on the forwarding
// tap, hand sequences for stall, flush, counter wrap and mid-stall reset.

module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0;
  logic        m_valid = 1'b0, m_reg_write_valid = 1'b0, m_mem_to_reg = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_alu_result = '0, m_load_data = '0;
  logic [3:0]  m_rd_byte_en = '0;
  logic [4:0]  rs_addr = '0, rt_addr = '0;
  logic [31:0] rs_data, rt_data, fwd_data, retired;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;

  int checks = 0;
  int errors = 0;

  wb_stage #(.NREG(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_reg_write_valid(m_reg_write_valid),
    .m_mem_to_reg(m_mem_to_reg), .m_rd(m_rd), .m_alu_result(m_alu_result),
    .m_load_data(m_load_data), .m_rd_byte_en(m_rd_byte_en),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, we, mtr;
    logic [4:0]  rd;
    logic [31:0] alu, ld;
    logic [3:0]  ben;
    logic [4:0]  ra, rb;
    logic [31:0] exp_a, exp_b;
    logic        exp_fv;
    logic [31:0] exp_fd;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } sb_t;

  vec_t vec[10];
  sb_t  sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, we, mtr, input logic [4:0] rd,
                       input logic [31:0] alu, ld, input logic [3:0] ben);
    m_valid = v; m_reg_write_valid = we; m_mem_to_reg = mtr;
    m_rd = rd; m_alu_result = alu; m_load_data = ld; m_rd_byte_en = ben;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 4'h0);
  endtask

  // Every forwarded write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && fwd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected act=r%0d:%h exp=none @%0t", fwd_addr, fwd_data, $time);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_fwd_addr", {27'b0, fwd_addr}, {27'b0, e.rd});
        chk("sb_fwd_data", fwd_data, e.d);
      end
    end
  end

  int exp_ret;

  initial begin
    //          v  we mtr rd  alu           ld            ben   ra rb exp_a         exp_b         fv fd
    vec[0] = '{1, 1, 0, 5,  32'h12345678, 32'h0,        4'h0, 5, 0, 32'h12345678, 32'h0,        1, 32'h12345678};
    vec[1] = '{1, 1, 0, 7,  32'hAABBCCDD, 32'h0,        4'h0, 7, 5, 32'hAABBCCDD, 32'h12345678, 1, 32'hAABBCCDD};
    vec[2] = '{1, 1, 1, 7,  32'h0,        32'h11223300, 4'hE, 7, 7, 32'h112233DD, 32'h112233DD, 1, 32'h112233DD};
    vec[3] = '{1, 1, 1, 7,  32'h12345678, 32'h44000000, 4'h8, 7, 5, 32'h442233DD, 32'h12345678, 1, 32'h442233DD};
    vec[4] = '{1, 1, 0, 0,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 0, 7, 32'h0,        32'h442233DD, 0, 32'h0};
    vec[5] = '{1, 1, 0, 3,  32'hCAFEF00D, 32'h0,        4'h0, 3, 0, 32'hCAFEF00D, 32'h0,        1, 32'hCAFEF00D};
    vec[6] = '{1, 0, 0, 3,  32'hDEADBEEF, 32'h0,        4'h0, 3, 3, 32'hCAFEF00D, 32'hCAFEF00D, 0, 32'h0};
    vec[7] = '{1, 1, 1, 3,  32'h0,        32'hFFFFFFFF, 4'h0, 3, 7, 32'hCAFEF00D, 32'h442233DD, 1, 32'hCAFEF00D};
    vec[8] = '{0, 1, 0, 6,  32'h1,        32'h0,        4'h0, 6, 3, 32'h0,        32'hCAFEF00D, 0, 32'h0};
    vec[9] = '{1, 1, 0, 6,  32'h66,       32'h0,        4'h0, 6, 6, 32'h66,       32'h66,       1, 32'h66};

    cyc(); cyc();
    rs_addr = 5'd5; rt_addr = 5'd7;
    #1;
    chk("rst_rs", rs_data, 32'h0);
    chk("rst_rt", rt_data, 32'h0);
    chk("rst_fwd_valid", {31'b0, fwd_valid}, 32'h0);
    chk("rst_fwd_addr", {27'b0, fwd_addr}, 32'h0);
    chk("rst_fwd_data", fwd_data, 32'h0);
    chk("rst_retired", retired, 32'h0);
    rst = 1'b0;

    exp_ret = 0;
    for (int i = 0; i < 10; i++) begin
      drive(vec[i].v, vec[i].we, vec[i].mtr, vec[i].rd, vec[i].alu, vec[i].ld, vec[i].ben);
      rs_addr = vec[i].ra; rt_addr = vec[i].rb;
      if (vec[i].exp_fv) sb.push_back('{vec[i].rd, vec[i].exp_fd});
      cyc();
      chk($sformatf("v%0d_rs", i), rs_data, vec[i].exp_a);
      chk($sformatf("v%0d_rt", i), rt_data, vec[i].exp_b);
      chk($sformatf("v%0d_fwd_valid", i), {31'b0, fwd_valid}, {31'b0, vec[i].exp_fv});
      chk($sformatf("v%0d_retired", i), retired, exp_ret);
      if (vec[i].v) exp_ret++;
    end
    bubble();
    cyc();
    chk("vec_retired_end", retired, exp_ret);

    // Stall: instruction held three cycles, then writes and counts once.
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h99999999, 32'h0, 4'h0);
    cyc();
    stall = 1'b1;
    bubble();
    rs_addr = 5'd9;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_fwd_valid", k), {31'b0, fwd_valid}, 32'h0);
      chk($sformatf("stall%0d_retired", k), retired, exp_ret);
      chk($sformatf("stall%0d_rs9", k), rs_data, 32'h0);
      cyc();
    end
    stall = 1'b0;
    sb.push_back('{5'd9, 32'h99999999});
    #1;
    chk("unstall_bypass", rs_data, 32'h99999999);
    cyc();
    exp_ret++;
    chk("unstall_retired", retired, exp_ret);
    chk("unstall_fwd_off", {31'b0, fwd_valid}, 32'h0);
    chk("unstall_r9", rs_data, 32'h99999999);

    // Flush wins over stall.
    drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h44444444, 32'h0, 4'h0);
    flush = 1'b1; stall = 1'b1;
    cyc();
    flush = 1'b0; stall = 1'b0;
    bubble();
    rs_addr = 5'd4;
    #1;
    chk("flush_fwd_valid", {31'b0, fwd_valid}, 32'h0);
    chk("flush_rs4", rs_data, 32'h0);
    cyc();
    chk("flush_retired", retired, exp_ret);
    chk("flush_r4", rs_data, 32'h0);

    // Counter wrap via preload.
    force dut.retired_q = 32'hFFFFFFFF;
    cyc();
    release dut.retired_q;
    #1;
    chk("wrap_preload", retired, 32'hFFFFFFFF);
    drive(1'b1, 1'b0, 1'b0, 5'd2, 32'h0, 32'h0, 4'h0);
    cyc();
    bubble();
    chk("wrap_before", retired, 32'hFFFFFFFF);
    cyc();
    chk("wrap_zero", retired, 32'h0);

    // Reset in the middle of a stall drops the held instruction.
    drive(1'b1, 1'b1, 1'b0, 5'd11, 32'h000000BB, 32'h0, 4'h0);
    cyc();
    stall = 1'b1;
    bubble();
    cyc();
    rst = 1'b1;
    cyc();
    rs_addr = 5'd7; rt_addr = 5'd5;
    #1;
    chk("mrst_rs", rs_data, 32'h0);
    chk("mrst_rt", rt_data, 32'h0);
    chk("mrst_fwd_valid", {31'b0, fwd_valid}, 32'h0);
    chk("mrst_fwd_addr", {27'b0, fwd_addr}, 32'h0);
    chk("mrst_fwd_data", fwd_data, 32'h0);
    chk("mrst_retired", retired, 32'h0);
    rst = 1'b0; stall = 1'b0;
    rs_addr = 5'd11; rt_addr = 5'd3;
    cyc();
    chk("post_rst_fwd_valid", {31'b0, fwd_valid}, 32'h0);
    chk("post_rst_retired", retired, 32'h0);
    chk("post_rst_r11", rs_data, 32'h0);
    chk("post_rst_r3", rt_data, 32'h0);

    cyc();
    chk("sb_empty", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
